result_mem_ctrl: RTL and testbench

//   Sequencer for the classifier result memory. Collects NUM_CLASS per-class scores streamed one per

---
 rtl/result_mem_ctrl_if.sv | 40 ++++
 rtl/result_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_result_mem_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_mem_ctrl_if.sv
// Bundle of the score stream, result memory strobes and CPU read handshake
// for the classifier result memory sequencer.
interface result_mem_ctrl_if #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16
);
  // Score stream from the final FC layer
  logic                        start;
  logic                        score_valid;
  logic [DATA_W-1:0]           score_data;
  logic                        score_last;
  logic                        score_ready;

  // Result memory side
  logic                        write_result_signal;
  logic [NUM_CLASS*DATA_W-1:0] write_result_data;
  logic                        read_result_signal;
  logic [31:0]                 read_result_data;

  // CPU read handshake and status
  logic                        cpu_rd_req;
  logic                        cpu_rd_ack;
  logic [31:0]                 cpu_rd_data;
  logic                        result_ready;
  logic                        seq_err;

  // Producer / CPU / memory-model side
  modport master (
    output start, score_valid, score_data, score_last, read_result_data, cpu_rd_req,
    input  score_ready, write_result_signal, write_result_data, read_result_signal,
           cpu_rd_ack, cpu_rd_data, result_ready, seq_err
  );

  // Controller side
  modport slave (
    input  start, score_valid, score_data, score_last, read_result_data, cpu_rd_req,
    output score_ready, write_result_signal, write_result_data, read_result_signal,
           cpu_rd_ack, cpu_rd_data, result_ready, seq_err
  );
endinterface

// File: rtl/result_mem_ctrl.sv
// Result memory sequencer: packs NUM_CLASS streamed scores into one word,
// commits it with a single-cycle write strobe, flags the result as ready and
// serves CPU reads through an independent two-stage read pipe.
module result_mem_ctrl #(
  parameter int NUM_CLASS     = 10,
  parameter int DATA_W        = 16,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic            clk,
  input  logic            rst,
  result_mem_ctrl_if.slave bus
);

  localparam int                PACK_W   = NUM_CLASS * DATA_W;
  localparam int                CNT_W    = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_cnt;
  logic [PACK_W-1:0]   r_pack;
  logic [PACK_W-1:0]   r_wr_data;
  logic                r_seq_err;

  // Read pipe: stage 1 = memory strobe cycle, stage 2 = ack cycle
  logic                r_s1_vld;
  logic                r_s1_done;
  logic                r_ack;
  logic                r_ack_done;
  logic [31:0]         r_rd_data;

  logic                w_clear;
  logic                w_accept;
  logic                w_final;
  logic                w_done_ack;
  logic [PACK_W-1:0]   w_pack_ins;

  logic                w_score_ready;
  logic                w_wr_strobe;
  logic                w_result_ready;

  // Handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    w_clear    = bus.start && (r_state != S_COMMIT);
    // a start in COLLECT has priority, so the score offered with it is dropped
    w_accept   = (r_state == S_COLLECT) && bus.score_valid && !bus.start;
    w_final    = w_accept && (r_cnt == LAST_IDX);
    w_done_ack = r_ack && r_ack_done && (CLEAR_ON_READ != 0);
  end

  // Current pack register with the incoming score inserted at slot r_cnt
  always_comb begin
    w_pack_ins = r_pack;
    for (int unsigned k = 0; k < NUM_CLASS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_pack_ins[k*DATA_W +: DATA_W] = bus.score_data;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (bus.start)    w_state_nxt = S_COLLECT;
        else if (w_final) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.start)       w_state_nxt = S_COLLECT;
        else if (w_done_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    w_score_ready  = 1'b0;
    w_wr_strobe    = 1'b0;
    w_result_ready = 1'b0;
    unique case (r_state)
      S_COLLECT: w_score_ready  = 1'b1;
      S_COMMIT:  w_wr_strobe    = 1'b1;
      S_DONE:    w_result_ready = 1'b1;
      default: ;
    endcase
  end

  // Score collection datapath: counter, pack register, committed word, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pack    <= '0;
      r_wr_data <= '0;
      r_seq_err <= 1'b0;
    end else if (w_clear) begin
      r_cnt     <= '0;
      r_pack    <= '0;
      r_seq_err <= 1'b0;
    end else if (w_accept) begin
      r_pack    <= w_pack_ins;
      r_cnt     <= w_final ? '0 : r_cnt + 1'b1;
      // score_last must coincide exactly with the final slot
      r_seq_err <= r_seq_err | (bus.score_last != w_final);
      // committed word is loaded with the final score so it is valid during COMMIT
      if (w_final) begin
        r_wr_data <= w_pack_ins;
      end
    end
  end

  // CPU read pipe: the DONE test is frozen at request time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_done  <= 1'b0;
      r_ack      <= 1'b0;
      r_ack_done <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_s1_vld <= bus.cpu_rd_req && !r_s1_vld;
      if (bus.cpu_rd_req && !r_s1_vld) begin
        r_s1_done <= (r_state == S_DONE);
      end
      r_ack      <= r_s1_vld;
      r_ack_done <= r_s1_vld && r_s1_done;
      if (r_s1_vld) begin
        r_rd_data <= r_s1_done ? bus.read_result_data : '1;
      end
    end
  end

  assign bus.score_ready         = w_score_ready;
  assign bus.write_result_signal = w_wr_strobe;
  assign bus.write_result_data   = r_wr_data;
  assign bus.read_result_signal  = r_s1_vld && r_s1_done;
  assign bus.cpu_rd_ack          = r_ack;
  assign bus.cpu_rd_data         = r_rd_data;
  assign bus.result_ready        = w_result_ready;
  assign bus.seq_err             = r_seq_err;

endmodule

// File: tb/tb_result_mem_ctrl.sv
// Self-checking bench for result_mem_ctrl: table-driven collection/read rows
// plus hand-written corner sequences; write words and CPU read data are
// checked through scoreboard queues popped when the DUT strobes.
module tb_result_mem_ctrl;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int PW = NC * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mem_word;

  result_mem_ctrl_if #(.NUM_CLASS(NC), .DATA_W(DW)) bus ();

  result_mem_ctrl #(.NUM_CLASS(NC), .DATA_W(DW), .CLEAR_ON_READ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: returns the stored word only while strobed
  assign bus.read_result_data = bus.read_result_signal ? mem_word : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [PW-1:0] exp_wr_q[$];
  logic [31:0]   exp_rd_q[$];

  typedef struct {
    int          gap;
    int          last_pos;
    logic        exp_err;
    logic [15:0] base;
    logic [31:0] mem;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [15:0] base);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < NC; k++) p[k*DW +: DW] = base + 16'(k);
    return p;
  endfunction

  // Scoreboard: pop and compare on each write strobe and each CPU ack
  always @(negedge clk) begin
    if (bus.write_result_signal === 1'b1) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) chk("unexpected_wr", bus.write_result_signal, 0);
      else chk("wr_data", bus.write_result_data, exp_wr_q.pop_front());
    end
    if (bus.cpu_rd_ack === 1'b1) begin
      if (exp_rd_q.size() == 0) chk("unexpected_ack", bus.cpu_rd_ack, 0);
      else chk("rd_data", bus.cpu_rd_data, exp_rd_q.pop_front());
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_score_ready"}, bus.score_ready, 0);
    chk({tag, "_wr_sig"},      bus.write_result_signal, 0);
    chk({tag, "_wr_data"},     bus.write_result_data, 0);
    chk({tag, "_rd_sig"},      bus.read_result_signal, 0);
    chk({tag, "_rd_ack"},      bus.cpu_rd_ack, 0);
    chk({tag, "_rd_data"},     bus.cpu_rd_data, 0);
    chk({tag, "_res_ready"},   bus.result_ready, 0);
    chk({tag, "_seq_err"},     bus.seq_err, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic send_scores(input logic [15:0] base, input int n, input int last_pos, input int gap);
    for (int k = 0; k < n; k++) begin
      bus.score_valid = 1'b1;
      bus.score_data  = base + 16'(k);
      bus.score_last  = (k == last_pos);
      @(posedge clk); #1;
      bus.score_valid = 1'b0;
      bus.score_last  = 1'b0;
      bus.score_data  = 16'hDEAD;
      if (k != n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Called just after the final accept edge
  task automatic check_commit(input logic [PW-1:0] exp_word, input logic exp_err);
    @(negedge clk);
    chk("wr_strobe_lat1", bus.write_result_signal, 1);
    chk("ready_not_early", bus.result_ready, 0);
    @(negedge clk);
    chk("wr_strobe_1cyc", bus.write_result_signal, 0);
    chk("ready_lat2", bus.result_ready, 1);
    chk("seq_err", bus.seq_err, exp_err);
    chk("wr_data_hold", bus.write_result_data, exp_word);
  endtask

  task automatic do_read(input logic exp_strobe, input logic [31:0] exp_data);
    @(posedge clk); #1 bus.cpu_rd_req = 1'b1;
    exp_rd_q.push_back(exp_data);
    @(negedge clk);
    chk("rd_sig_at_N", bus.read_result_signal, 0);
    @(posedge clk); #1 bus.cpu_rd_req = 1'b0;
    @(negedge clk);
    chk("rd_sig_at_N1", bus.read_result_signal, exp_strobe);
    chk("ack_at_N1", bus.cpu_rd_ack, 0);
    @(negedge clk);
    chk("ack_at_N2", bus.cpu_rd_ack, 1);
  endtask

  initial begin
    int wr_before;

    vecs[0] = '{gap: 0, last_pos: 9,  exp_err: 1'b0, base: 16'h0001, mem: 32'd7};
    vecs[1] = '{gap: 1, last_pos: 9,  exp_err: 1'b0, base: 16'h0001, mem: 32'd7};
    vecs[2] = '{gap: 0, last_pos: 3,  exp_err: 1'b1, base: 16'h0100, mem: 32'h0000_1234};
    vecs[3] = '{gap: 0, last_pos: -1, exp_err: 1'b1, base: 16'hF000, mem: 32'hA5A5_0003};
    vecs[4] = '{gap: 2, last_pos: 9,  exp_err: 1'b0, base: 16'h7FF0, mem: 32'd9};

    rst             = 1'b1;
    mem_word        = '0;
    bus.start       = 1'b0;
    bus.score_valid = 1'b0;
    bus.score_data  = '0;
    bus.score_last  = 1'b0;
    bus.cpu_rd_req  = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Table rows: collect, commit, then a DONE-sourced read that clears the result
    for (int i = 0; i < 5; i++) begin
      pulse_start();
      chk("collect_ready", bus.score_ready, 1);
      chk("start_clears_err", bus.seq_err, 0);
      exp_wr_q.push_back(pack(vecs[i].base));
      send_scores(vecs[i].base, NC, vecs[i].last_pos, vecs[i].gap);
      check_commit(pack(vecs[i].base), vecs[i].exp_err);
      mem_word = vecs[i].mem;
      do_read(1'b1, vecs[i].mem);
      @(negedge clk);
      chk("clear_on_read_ready", bus.result_ready, 0);
      chk("clear_on_read_idle", bus.score_ready, 0);
    end

    // Read while not DONE: no strobe, all-ones data
    do_read(1'b0, 32'hFFFF_FFFF);

    // Second request while a read is in flight is ignored
    @(posedge clk); #1 bus.cpu_rd_req = 1'b1;
    exp_rd_q.push_back(32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1 bus.cpu_rd_req = 1'b0;
    @(negedge clk);
    chk("inflight_ack", bus.cpu_rd_ack, 1);
    @(negedge clk);
    chk("inflight_ignored", bus.cpu_rd_ack, 0);

    // Start in the ack cycle wins over the clear-on-read return to IDLE
    pulse_start();
    exp_wr_q.push_back(pack(16'h0400));
    send_scores(16'h0400, NC, 9, 0);
    check_commit(pack(16'h0400), 1'b0);
    mem_word = 32'h0C0F_FEE0;
    @(posedge clk); #1 bus.cpu_rd_req = 1'b1;
    exp_rd_q.push_back(32'h0C0F_FEE0);
    @(posedge clk); #1 bus.cpu_rd_req = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(negedge clk);
    chk("start_win_ack", bus.cpu_rd_ack, 1);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("start_win_collect", bus.score_ready, 1);
    chk("start_win_not_ready", bus.result_ready, 0);

    // Restart after 5 scores; the score offered with start is dropped
    send_scores(16'h0500, 5, -1, 0);
    bus.start       = 1'b1;
    bus.score_valid = 1'b1;
    bus.score_data  = 16'hEEEE;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.score_valid = 1'b0;
    exp_wr_q.push_back(pack(16'h0200));
    send_scores(16'h0200, NC, 9, 0);
    check_commit(pack(16'h0200), 1'b0);

    // Async reset mid-collection
    pulse_start();
    send_scores(16'h0300, 4, -1, 0);
    wr_before = wr_cnt;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("no_wr_after_rst", wr_cnt, wr_before);
    chk("idle_after_rst", bus.score_ready, 0);

    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
